// File: rtl/shift_seq_pkg.sv
// Shared constants and state encoding for the multi-cycle right-shift sequencer.
package shift_seq_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_e;

  // Largest single-cycle step of the shift unit and the width of its select.
  localparam int STEP_MAX = 3;
  localparam int SEL_W    = 2;

endpackage

// File: rtl/shift_step.sv
// One 0-3 position shift step; right logical/arithmetic, plus left when SHIFT_LEFT_EN is defined.
module shift_step
  import shift_seq_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] data,
  input  logic [SEL_W-1:0] sel,
  input  logic             arith,
`ifdef SHIFT_LEFT_EN
  input  logic             left,
`endif
  output logic [WIDTH-1:0] result
);

  always_comb begin
    result = data;
`ifdef SHIFT_LEFT_EN
    if (left) begin
      result = data << sel;
    end else if (arith) begin
      result = $signed(data) >>> sel;
    end else begin
      result = data >> sel;
    end
`else
    if (arith) begin
      result = $signed(data) >>> sel;
    end else begin
      result = data >> sel;
    end
`endif
  end

endmodule

// File: rtl/shift_sequencer.sv
// Multi-cycle shift controller: accepts an operand, shifts it 0-3 places per cycle, returns the result.
// Optional left shifts are enabled by defining SHIFT_LEFT_EN (adds the req_left port).
module shift_sequencer
  import shift_seq_pkg::*;
#(
  parameter  int WIDTH = 8,
  localparam int AMT_W = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [WIDTH-1:0] req_data,
  input  logic [AMT_W-1:0] req_amt,
  input  logic             req_arith,
`ifdef SHIFT_LEFT_EN
  input  logic             req_left,
`endif
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] rsp_data,
  output logic             busy,
  output logic [1:0]       dbg_state
);

  localparam logic [1:0] IDLE  = ST_IDLE;
  localparam logic [1:0] SHIFT = ST_SHIFT;
  localparam logic [1:0] DONE  = ST_DONE;

  logic [1:0]       state;
  logic [WIDTH-1:0] operand;
  logic [WIDTH-1:0] step_out;
  logic [AMT_W-1:0] remaining;
  logic [AMT_W-1:0] rem_next;
  logic [SEL_W-1:0] sel;
  logic             arith_q;
  logic             accept;
`ifdef SHIFT_LEFT_EN
  logic             left_q;
`endif

  // Both ports use valid/ready: a transfer happens on a rising edge where valid and ready are
  // both high; the sender holds its payload stable until then. One transaction is in flight.
  assign accept    = req_valid && req_ready;
  assign req_ready = rst_n && (state == IDLE);
  assign rsp_valid = (state == DONE);
  assign busy      = (state == SHIFT) || (state == DONE);
  assign dbg_state = state;

  assign sel      = (remaining >= AMT_W'(STEP_MAX)) ? SEL_W'(STEP_MAX) : SEL_W'(remaining);
  assign rem_next = remaining - AMT_W'(sel);

  shift_step #(.WIDTH(WIDTH)) u_step (
    .data   (operand),
    .sel    (sel),
    .arith  (arith_q),
`ifdef SHIFT_LEFT_EN
    .left   (left_q),
`endif
    .result (step_out)
  );

  // rsp_data is loaded only on entry to DONE, so it stays stable through any backpressure.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      operand   <= '0;
      remaining <= '0;
      arith_q   <= 1'b0;
      rsp_data  <= '0;
`ifdef SHIFT_LEFT_EN
      left_q    <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            operand   <= req_data;
            remaining <= req_amt;
            arith_q   <= req_arith;
`ifdef SHIFT_LEFT_EN
            left_q    <= req_left;
`endif
            if (req_amt == '0) begin
              state    <= DONE;
              rsp_data <= req_data;
            end else begin
              state <= SHIFT;
            end
          end
        end
        SHIFT: begin
          operand   <= step_out;
          remaining <= rem_next;
          if (rem_next == '0) begin
            state    <= DONE;
            rsp_data <= step_out;
          end
        end
        DONE: begin
          if (rsp_ready) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_shift_sequencer.sv
// Self-checking bench for shift_sequencer: directed table, hand-written corner sequences, random vs model.
module tb_shift_sequencer;

  localparam int W = 8;

  logic         clk;
  logic         rst_n;
  logic         req_valid;
  logic         req_ready;
  logic [W-1:0] req_data;
  logic [2:0]   req_amt;
  logic         req_arith;
  logic         req_left;
  logic         rsp_valid;
  logic         rsp_ready;
  logic [W-1:0] rsp_data;
  logic         busy;
  logic [1:0]   dbg_state;

  int total;
  int bad;
  logic [W-1:0] exp_q[$];

  typedef struct {
    logic [W-1:0] data;
    logic [2:0]   amt;
    logic         arith;
    logic [W-1:0] exp_data;
    int           exp_lat;
  } vec_t;

  vec_t vecs[8];

  shift_sequencer #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_data  (req_data),
    .req_amt   (req_amt),
    .req_arith (req_arith),
`ifdef SHIFT_LEFT_EN
    .req_left  (req_left),
`endif
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_data  (rsp_data),
    .busy      (busy),
    .dbg_state (dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  // Reference model: the result is the operand shifted by the whole amount in one go.
  function automatic logic [W-1:0] model_data(input logic [W-1:0] d, input logic [2:0] a,
                                             input logic ar, input logic lf);
    logic [2*W-1:0] ext;
    logic [2*W-1:0] tmp;
    if (lf) begin
      tmp = {{W{1'b0}}, d} << a;
    end else begin
      ext = {{W{ar & d[W-1]}}, d};
      tmp = ext >> a;
    end
    return tmp[W-1:0];
  endfunction

  // Edges from acceptance (inclusive) to rsp_valid: one per 3 positions, plus the accept edge.
  function automatic int model_lat(input logic [2:0] a);
    return (int'(a) + 2) / 3 + 1;
  endfunction

  // Driver: one request, then observe latency, data, backpressure stability and 1-cycle response.
  task automatic do_txn(input logic [W-1:0] d, input logic [2:0] a, input logic ar,
                        input logic lf, input logic [W-1:0] exp_d, input int exp_lat,
                        input int stall, input string name);
    int cnt;
    logic [W-1:0] want;
    exp_q.push_back(exp_d);
    @(negedge clk);
    req_valid = 1'b1;
    req_data  = d;
    req_amt   = a;
    req_arith = ar;
    req_left  = lf;
    rsp_ready = (stall == 0);
    chk({name, "_req_ready"}, 32'(req_ready), 32'd1);
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    req_data  = $urandom_range(0, 255);
    cnt = 1;
    while (!rsp_valid && cnt < 20) begin
      @(negedge clk);
      cnt++;
    end
    want = exp_q.pop_front();
    chk({name, "_latency"}, 32'(cnt), 32'(exp_lat));
    chk({name, "_data"}, 32'(rsp_data), 32'(want));
    for (int i = 0; i < stall; i++) begin
      @(negedge clk);
      chk({name, "_hold_valid"}, 32'(rsp_valid), 32'd1);
      chk({name, "_hold_data"}, 32'(rsp_data), 32'(want));
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    chk({name, "_one_cycle"}, 32'(rsp_valid), 32'd0);
    chk({name, "_data_kept"}, 32'(rsp_data), 32'(want));
  endtask

  initial begin : main
    int cnt;
    logic [W-1:0] d;
    logic [2:0] a;
    logic ar;

    total = 0;
    bad = 0;
    vecs[0] = '{8'h96, 3'd5, 1'b1, 8'hFC, 3};
    vecs[1] = '{8'h96, 3'd5, 1'b0, 8'h04, 3};
    vecs[2] = '{8'h96, 3'd0, 1'b1, 8'h96, 1};
    vecs[3] = '{8'h80, 3'd7, 1'b1, 8'hFF, 4};
    vecs[4] = '{8'h7F, 3'd1, 1'b1, 8'h3F, 2};
    vecs[5] = '{8'hC3, 3'd6, 1'b1, 8'hFF, 3};
    vecs[6] = '{8'hC3, 3'd4, 1'b0, 8'h0C, 3};
    vecs[7] = '{8'hFF, 3'd3, 1'b0, 8'h1F, 2};

    rst_n = 1'b0;
    req_valid = 1'b0;
    req_data = '0;
    req_amt = '0;
    req_arith = 1'b0;
    req_left = 1'b0;
    rsp_ready = 1'b1;
    #12;
    chk("reset_req_ready", 32'(req_ready), 32'd0);
    chk("reset_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("reset_rsp_data", 32'(rsp_data), 32'd0);
    chk("reset_busy", 32'(busy), 32'd0);
    chk("reset_state", 32'(dbg_state), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("post_reset_req_ready", 32'(req_ready), 32'd1);

    // Directed table
    for (int i = 0; i < 8; i++) begin
      do_txn(vecs[i].data, vecs[i].amt, vecs[i].arith, 1'b0, vecs[i].exp_data,
             vecs[i].exp_lat, 0, $sformatf("vec%0d", i));
    end

    // Backpressure: hold rsp_ready low; a second request during DONE must be ignored.
    @(negedge clk);
    req_valid = 1'b1; req_data = 8'h80; req_amt = 3'd7; req_arith = 1'b1;
    rsp_ready = 1'b0;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    cnt = 1;
    while (!rsp_valid && cnt < 20) begin
      @(negedge clk);
      cnt++;
    end
    chk("hold_latency", 32'(cnt), 32'd4);
    req_valid = 1'b1; req_data = 8'h11; req_amt = 3'd1; req_arith = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("hold_valid", 32'(rsp_valid), 32'd1);
      chk("hold_data", 32'(rsp_data), 32'hFF);
      chk("hold_req_ready", 32'(req_ready), 32'd0);
      chk("hold_busy", 32'(busy), 32'd1);
    end
    req_valid = 1'b0;
    rsp_ready = 1'b1;
    @(negedge clk);
    chk("hold_release", 32'(rsp_valid), 32'd0);
    chk("hold_idle_ready", 32'(req_ready), 32'd1);
    repeat (3) @(negedge clk);
    chk("hold_no_ghost", 32'(rsp_valid), 32'd0);
    chk("hold_no_ghost_busy", 32'(busy), 32'd0);

    // Back-to-back: req_valid held across two logical requests.
    @(negedge clk);
    req_valid = 1'b1; req_data = 8'h40; req_amt = 3'd2; req_arith = 1'b0;
    @(posedge clk);
    @(negedge clk);
    req_data = 8'h7F; req_amt = 3'd3;
    cnt = 1;
    while (!rsp_valid && cnt < 20) begin
      @(negedge clk);
      cnt++;
    end
    chk("b2b_first_lat", 32'(cnt), 32'd2);
    chk("b2b_first_data", 32'(rsp_data), 32'h10);
    @(negedge clk);
    chk("b2b_gap_valid", 32'(rsp_valid), 32'd0);
    chk("b2b_gap_ready", 32'(req_ready), 32'd1);
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    cnt = 1;
    while (!rsp_valid && cnt < 20) begin
      @(negedge clk);
      cnt++;
    end
    chk("b2b_second_lat", 32'(cnt), 32'd2);
    chk("b2b_second_data", 32'(rsp_data), 32'h0F);
    @(negedge clk);
    chk("b2b_done", 32'(rsp_valid), 32'd0);

    // Reset in the middle of a shift aborts the transaction.
    @(negedge clk);
    req_valid = 1'b1; req_data = 8'hAA; req_amt = 3'd6; req_arith = 1'b1;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    chk("abort_busy_before", 32'(busy), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("abort_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_rsp_data", 32'(rsp_data), 32'd0);
    chk("abort_req_ready", 32'(req_ready), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("abort_release_ready", 32'(req_ready), 32'd1);
    cnt = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (rsp_valid) cnt++;
    end
    chk("abort_no_response", 32'(cnt), 32'd0);

`ifdef SHIFT_LEFT_EN
    do_txn(8'h96, 3'd3, 1'b1, 1'b1, 8'hB0, 2, 0, "left_shift");
`endif

    // Random transactions against the model, with random backpressure.
    for (int i = 0; i < 40; i++) begin
      d  = W'($urandom_range(0, 255));
      a  = 3'($urandom_range(0, 7));
      ar = 1'($urandom_range(0, 1));
      do_txn(d, a, ar, 1'b0, model_data(d, a, ar, 1'b0), model_lat(a),
             $urandom_range(0, 2), $sformatf("rnd%0d", i));
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

endmodule
